// File: rtl/ddi_pkg.sv
// Shared constants and types for the demand detector.
// Lane count, lane index type, queue count width and light_state-to-lane mapping.
package ddi_pkg;

  localparam int unsigned NUM_LANES  = 4;
  localparam int unsigned LANE_IDX_W = 2;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned AGE_W      = 8;

  typedef logic [LANE_IDX_W-1:0] lane_idx_t;
  typedef logic [CNT_W-1:0]      cnt_t;

  localparam cnt_t CNT_MAX = '1;
  localparam cnt_t CNT_ONE = CNT_W'(1);

  // light_state bit that marks each lane as served
  localparam int unsigned LIGHT_BIT [NUM_LANES] = '{0, 1, 2, 3};

endpackage

// File: rtl/lane_demand.sv
// One lane: det synchronizer + rise detect, saturating queue count, drain timer.
// Wait-age counter exists only when DEMAND_STARVE_EN is defined.
module lane_demand
  import ddi_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic det,
  input  logic served,
  output cnt_t count
`ifdef DEMAND_STARVE_EN
  ,
  output logic [AGE_W-1:0] age
`endif
);

  localparam int unsigned       TMR_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(DRAIN_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             sync3;
  logic [TMR_W-1:0] tmr;
  logic             arrival;
  logic             drain;

  // Two-flop synchronizer plus a third flop for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= det;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign arrival = sync2 & ~sync3;
  assign drain   = served && (tmr == TMR_LAST);

  always_ff @(posedge clk) begin
    if (rst || !served) begin
      tmr <= '0;
    end else if (drain) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + TMR_W'(1);
    end
  end

  // Arrival and drain together cancel; saturate at both ends
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (arrival && !drain && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end else if (drain && !arrival && (count != '0)) begin
      count <= count - CNT_ONE;
    end
  end

`ifdef DEMAND_STARVE_EN
  always_ff @(posedge clk) begin
    if (rst || served || (count == '0)) begin
      age <= '0;
    end else if (age != '1) begin
      age <= age + AGE_W'(1);
    end
  end
`endif

endmodule

// File: rtl/demand_detector.sv
// Four-lane traffic demand detector: per-lane queues feed a registered priority selector.
// Define DEMAND_STARVE_EN to compile in wait-age starvation override.
module demand_detector
  import ddi_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 8,
  parameter int unsigned STARVE_LIMIT = 200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] det,
  input  logic [NUM_LANES-1:0] light_state,
  output lane_idx_t            priority_idx,
  output logic                 demand_any
);

  if (DRAIN_CYCLES == 0 || STARVE_LIMIT > 255) begin : g_bad_cfg
    $error("demand_detector: unsupported DRAIN_CYCLES or STARVE_LIMIT");
  end

  cnt_t      count [NUM_LANES];
  logic      any_c;
  lane_idx_t sel_c;
  cnt_t      best_cnt;
`ifdef DEMAND_STARVE_EN
  logic [AGE_W-1:0] age [NUM_LANES];
  logic             starve_c;
`endif

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_demand #(
      .DRAIN_CYCLES(DRAIN_CYCLES)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .det   (det[g]),
      .served(light_state[LIGHT_BIT[g]]),
      .count (count[g])
`ifdef DEMAND_STARVE_EN
      ,
      .age   (age[g])
`endif
    );
  end

  // Largest count wins with ties to lowest index; a starved lane overrides
  always_comb begin
    any_c    = 1'b0;
    sel_c    = '0;
    best_cnt = count[0];
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (count[i] != '0) any_c = 1'b1;
      if (count[i] > best_cnt) begin
        best_cnt = count[i];
        sel_c    = LANE_IDX_W'(i);
      end
    end
`ifdef DEMAND_STARVE_EN
    starve_c = 1'b0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (!starve_c && (32'(age[i]) >= STARVE_LIMIT)) begin
        starve_c = 1'b1;
        sel_c    = LANE_IDX_W'(i);
      end
    end
`endif
  end

  // Priority holds when there is no demand at all
  always_ff @(posedge clk) begin
    if (rst) begin
      priority_idx <= '0;
      demand_any   <= 1'b0;
    end else begin
      demand_any <= any_c;
      if (any_c) priority_idx <= sel_c;
    end
  end

endmodule
